// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient controller: input FIFO -> line-buffer window -> output FIFO.
// Define SOBEL_BORDER_ZERO_EN to force outputs for border centre pixels to 0.
module sobel_filter #(
  parameter int IMG_WIDTH  = 540,
  parameter int IMG_HEIGHT = 360
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_empty,
  input  logic [7:0]      in_dout,
  output logic            in_rd_en,
  output logic            shift_en,
  output logic [7:0]      pixel_in,
  input  logic [7:0][7:0] window,
  input  logic            out_full,
  output logic            out_wr_en,
  output logic [7:0]      out_din
);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int FILL_W = $clog2(IMG_WIDTH + 2);
  localparam logic [COL_W-1:0]  COL_LAST        = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST        = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]  STREAM_LAST_COL = COL_W'(IMG_WIDTH - 3);
  localparam logic [ROW_W-1:0]  STREAM_LAST_ROW = ROW_W'(IMG_HEIGHT - 2);
  localparam logic [FILL_W-1:0] FILL_LAST       = FILL_W'(IMG_WIDTH + 1);

  typedef enum logic [1:0] {PRELOAD, STREAM, FLUSH} state_t;

  state_t             state_reg;
  logic [COL_W-1:0]   col_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic               advance;
  logic               reading;
  logic               writing;
  logic               border;

  logic signed [10:0] nb [8];
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        abs_gx;
  logic [10:0]        abs_gy;
  logic [10:0]        mag;
  logic [7:0]         sat_mag;

  for (genvar gi = 0; gi < 8; gi++) begin : g_nb
    assign nb[gi] = $signed({3'b000, window[gi]});
  end

  // Index map: 7=TL 6=TM 5=TR 4=ML 3=MR 2=BL 1=BM 0=BR
  always_comb begin
    gx      = (nb[5] + (nb[3] <<< 1) + nb[0]) - (nb[7] + (nb[4] <<< 1) + nb[2]);
    gy      = (nb[2] + (nb[1] <<< 1) + nb[0]) - (nb[7] + (nb[6] <<< 1) + nb[5]);
    abs_gx  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag     = (abs_gx + abs_gy) >> 1;
    sat_mag = (mag > 11'd255) ? 8'hFF : mag[7:0];
  end

`ifdef SOBEL_BORDER_ZERO_EN
  assign border = (row_reg == '0) || (row_reg == ROW_LAST) ||
                  (col_reg == '0) || (col_reg == COL_LAST);
`else
  assign border = 1'b0;
`endif

  always_comb begin
    advance = 1'b0;
    reading = 1'b0;
    writing = 1'b0;
    if (!reset) begin
      case (state_reg)
        PRELOAD: begin
          advance = !in_empty;
          reading = !in_empty;
        end
        STREAM: begin
          advance = !in_empty && !out_full;
          reading = advance;
          writing = advance;
        end
        FLUSH: begin
          advance = !out_full;
          writing = !out_full;
        end
        default: ;
      endcase
    end
  end

  assign shift_en  = advance;
  assign in_rd_en  = reading;
  assign out_wr_en = writing;
  assign pixel_in  = reading ? in_dout : 8'd0;
  assign out_din   = (writing && !border) ? sat_mag : 8'd0;

  // Row/column track the centre pixel of the window being written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= PRELOAD;
      col_reg   <= '0;
      row_reg   <= '0;
      fill_reg  <= '0;
    end else if (advance) begin
      case (state_reg)
        PRELOAD: begin
          if (fill_reg == FILL_LAST) begin
            fill_reg  <= '0;
            state_reg <= STREAM;
          end else begin
            fill_reg <= fill_reg + 1'b1;
          end
        end
        STREAM, FLUSH: begin
          if (col_reg == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
          if (state_reg == STREAM && row_reg == STREAM_LAST_ROW && col_reg == STREAM_LAST_COL)
            state_reg <= FLUSH;
          if (state_reg == FLUSH && row_reg == ROW_LAST && col_reg == COL_LAST)
            state_reg <= PRELOAD;
        end
        default: state_reg <= PRELOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter: FIFO and line-buffer models plus a raster-index gradient reference.
module tb_sobel_filter;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;
`ifdef SOBEL_BORDER_ZERO_EN
  localparam bit BORDER_ZERO = 1'b1;
`else
  localparam bit BORDER_ZERO = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_empty = 1'b1;
  logic [7:0]      in_dout = 8'd0;
  logic            in_rd_en;
  logic            shift_en;
  logic [7:0]      pixel_in;
  logic [7:0][7:0] window = '0;
  logic            out_full = 1'b0;
  logic            out_wr_en;
  logic [7:0]      out_din;

  sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .shift_en(shift_en), .pixel_in(pixel_in), .window(window),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pat;
    int r;
    int c;
    int exp;
  } vec_t;
  localparam int NV = 12;
  vec_t tbl [NV];

  int hist [8192];          // every pixel ever pushed into the window, in order
  int hist_len = 0;
  int in_q [$];
  bit force_empty = 1'b0;
  int frame_base = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit frame_done = 1'b0;
  int got_img [N];
  int clean_img [N];
  int rnd_img [N];
  int compared = 0;
  int mismatched = 0;
  bit s_shift, s_rd;
  logic [7:0] s_pix;

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int hv(input int i);
    return (i < 0) ? 0 : hist[i];
  endfunction

  // Reference: Sobel magnitude around raster index g of the pushed stream.
  function automatic int ref_mag(input int g, input int r, input int c);
    int gx, gy, m;
    gx = hv(g-W+1) + 2*hv(g+1) + hv(g+W+1) - hv(g-W-1) - 2*hv(g-1) - hv(g+W-1);
    gy = hv(g+W-1) + 2*hv(g+W) + hv(g+W+1) - hv(g-W-1) - 2*hv(g-W) - hv(g-W+1);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    if (BORDER_ZERO && (r == 0 || r == H-1 || c == 0 || c == W-1)) m = 0;
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0: return 100;
      1: return (c >= 2) ? 255 : 0;
      2: return (r == 2 && c == 2) ? 40 : 0;
      default: return rnd_img[r*W+c];
    endcase
  endfunction

  task automatic drive_in();
    in_empty = force_empty || (in_q.size() == 0);
    in_dout  = (in_q.size() > 0) ? 8'(in_q[0]) : 8'd0;
  endtask

  task automatic update_window();
    window[0] = 8'(hv(hist_len-1));
    window[1] = 8'(hv(hist_len-2));
    window[2] = 8'(hv(hist_len-3));
    window[3] = 8'(hv(hist_len-W-1));
    window[4] = 8'(hv(hist_len-W-3));
    window[5] = 8'(hv(hist_len-2*W-1));
    window[6] = 8'(hv(hist_len-2*W-2));
    window[7] = 8'(hv(hist_len-2*W-3));
  endtask

  task automatic load_image(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        in_q.push_back(pix(pat, r, c));
  endtask

  task automatic step(input bit gate, input bit full);
    int viol, k, e;
    bit last;
    @(negedge clock);
    force_empty = gate;
    out_full = full;
    drive_in();
    #1;
    s_shift = shift_en;
    s_rd = in_rd_en;
    s_pix = pixel_in;
    last = 1'b0;
    if (reset) begin
      check("reset_quiet", int'({in_rd_en, shift_en, out_wr_en, pixel_in, out_din}), 0);
    end else begin
      viol = 0;
      if (in_empty && out_full && shift_en) viol |= 1;
      if (!in_empty && !out_full && !shift_en) viol |= 2;
      if ((in_rd_en && in_empty) || (out_wr_en && out_full)) viol |= 4;
      if (!shift_en && (in_rd_en || out_wr_en || pixel_in != 0 || out_din != 0)) viol |= 8;
      if (shift_en && !in_rd_en && !out_wr_en) viol |= 16;
      if (in_rd_en && pixel_in != in_dout) viol |= 32;
      if (shift_en && !in_rd_en && pixel_in != 0) viol |= 64;
      check("protocol", viol, 0);
      if (out_wr_en) begin
        k = wr_cnt;
        e = ref_mag(frame_base + k, k / W, k % W);
        $display("write (%0d,%0d) out=%0d exp=%0d", k / W, k % W, out_din, e);
        check("out_din", int'(out_din), e);
        got_img[k] = int'(out_din);
        wr_cnt++;
        if (wr_cnt == N) begin
          check("reads_per_frame", rd_cnt + int'(in_rd_en), N);
          last = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    if (s_shift) begin
      hist[hist_len] = int'(s_pix);
      hist_len++;
    end
    if (s_rd) begin
      void'(in_q.pop_front());
      rd_cnt++;
    end
    if (last) begin
      frame_base = hist_len;
      wr_cnt = 0;
      rd_cnt = 0;
      frame_done = 1'b1;
    end
    drive_in();
    update_window();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    in_q.delete();
    @(negedge clock);
    reset = 1'b0;
    drive_in();
    frame_base = hist_len;
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  // mode 0: free-running, 1: random empty + 10-cycle full stall in STREAM, 2: random flags
  task automatic run_frame(input int pat, input int mode, input int abort_at, input bit load);
    int cyc, stall;
    bit g, f, in_stream;
    cyc = 0;
    stall = 10;
    if (load) load_image(pat);
    frame_done = 1'b0;
    while (!frame_done && !(abort_at > 0 && rd_cnt >= abort_at)) begin
      g = 1'b0;
      f = 1'b0;
      if (mode >= 1) g = ($urandom_range(0, 3) == 0);
      if (mode == 2) f = ($urandom_range(0, 3) == 0);
      in_stream = (rd_cnt >= W + 2) && (rd_cnt < N);
      if (mode == 1 && in_stream && stall > 0) begin
        f = 1'b1;
        stall--;
      end
      step(g, f);
      if (mode == 1 && f && in_stream) check("stall_blocks", int'(s_shift), 0);
      cyc++;
      if (cyc > 8 * N + 100) begin
        check("frame_timeout", cyc, 0);
        break;
      end
    end
  endtask

  task automatic table_check(input int pat);
    for (int i = 0; i < NV; i++)
      if (tbl[i].pat == pat)
        check($sformatf("tbl_p%0d_r%0d_c%0d", pat, tbl[i].r, tbl[i].c),
              got_img[tbl[i].r*W + tbl[i].c], tbl[i].exp);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 1, 0};
    tbl[1]  = '{0, 2, 2, 0};
    tbl[2]  = '{0, 3, 3, 0};
    tbl[3]  = '{1, 1, 1, 255};
    tbl[4]  = '{1, 2, 1, 255};
    tbl[5]  = '{1, 2, 2, 255};
    tbl[6]  = '{1, 3, 3, 0};
    tbl[7]  = '{2, 1, 1, 40};
    tbl[8]  = '{2, 1, 2, 40};
    tbl[9]  = '{2, 2, 2, 0};
    tbl[10] = '{2, 2, 3, 40};
    tbl[11] = '{2, 3, 3, 40};

    do_reset();

    run_frame(0, 0, 0, 1'b1);
    table_check(0);

    // Fresh frame in PRELOAD must advance even with the output FIFO full.
    load_image(1);
    step(1'b0, 1'b1);
    check("preload_ignores_full", int'(s_shift), 1);
    check("preload_reads", int'(s_rd), 1);
    run_frame(1, 0, 0, 1'b0);
    table_check(1);

    run_frame(2, 0, 0, 1'b1);
    table_check(2);
    for (int i = 0; i < N; i++) clean_img[i] = got_img[i];

    run_frame(2, 1, 0, 1'b1);
    table_check(2);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        check($sformatf("stall_vs_clean_r%0d_c%0d", r, c), got_img[r*W+c], clean_img[r*W+c]);

    // Abandon a frame after 9 inputs, then resend it from the top.
    run_frame(2, 0, 9, 1'b1);
    do_reset();
    run_frame(2, 0, 0, 1'b1);
    table_check(2);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        check($sformatf("reset_vs_clean_r%0d_c%0d", r, c), got_img[r*W+c], clean_img[r*W+c]);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) rnd_img[i] = int'($urandom_range(0, 255));
      run_frame(3, 2, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end
endmodule
